// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage RV32I pipeline: load-use bubble, branch squash, dmem freeze with watchdog.
// Enables/flushes are combinational (Mealy); a dmem wait freezes the whole pipe until ack, withdrawal or timeout.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req_valid,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
  } ctl_t;

  localparam ctl_t CTL_NORMAL = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1,
                                  ifid_flush: 1'b0, idex_flush: 1'b0};
  localparam ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
                                  ifid_flush: 1'b0, idex_flush: 1'b0};
  localparam ctl_t CTL_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0,
                                  ifid_flush: 1'b1, idex_flush: 1'b1};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;

  logic uses_rs1, uses_rs2, lu, mw;
  ctl_t run_ctl, fsm_ctl, ctl;

  // Opcodes outside the RV32I set below (FENCE, SYSTEM, illegal) read no register.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_JALR, OP_LOAD, OP_IMM:       uses_rs1 = 1'b1;
      OP_BRANCH, OP_STORE, OP_REG: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC, OP_JAL:       uses_rs1 = 1'b0;
      default:                        uses_rs1 = 1'b0;
    endcase
  end

  assign lu = ex_memread && (ex_rd != 5'd0) &&
              (((ex_rd == id_rs1) && uses_rs1) || ((ex_rd == id_rs2) && uses_rs2));
  assign mw = mem_req_valid && !dmem_ack;

  // Unfrozen behaviour: a taken branch squashes ID, so it outranks the load-use bubble.
  always_comb begin
    run_ctl = CTL_NORMAL;
    if (ex_branch_taken) begin
      run_ctl.ifid_flush = 1'b1;
      run_ctl.idex_flush = 1'b1;
    end else if (lu) begin
      run_ctl.pc_en      = 1'b0;
      run_ctl.ifid_en    = 1'b0;
      run_ctl.idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Withdrawing the request in MEM_WAIT releases the pipe exactly like an ack.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    fsm_ctl      = run_ctl;
    case (state)
      RUN: begin
        if (mw) begin
          fsm_ctl      = CTL_FREEZE;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mw) begin
          fsm_ctl      = CTL_FREEZE;
          wait_cnt_nxt = wait_cnt + WC_W'(1);
          if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
            state_nxt = ERROR;
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      ERROR: begin
        fsm_ctl = CTL_FREEZE;
      end
      default: begin
        fsm_ctl   = CTL_FREEZE;
        state_nxt = RUN;
      end
    endcase
  end

  assign ctl = rst_n ? fsm_ctl : CTL_RESET;

  assign pc_en      = ctl.pc_en;
  assign ifid_en    = ctl.ifid_en;
  assign idex_en    = ctl.idex_en;
  assign exmem_en   = ctl.exmem_en;
  assign ifid_flush = ctl.ifid_flush;
  assign idex_flush = ctl.idex_flush;
  assign mem_err    = (state == ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: RUN-state vector table plus mem-wait, timeout, saturation and reset sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, ex_branch_taken, mem_req_valid, dmem_ack;
  logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mem_err;
  logic [3:0] stall_cnt;
  logic [5:0] outs;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_req_valid(mem_req_valid), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};

  localparam logic [5:0] O_NORM   = 6'b111100;
  localparam logic [5:0] O_LU     = 6'b001101;
  localparam logic [5:0] O_BR     = 6'b111111;
  localparam logic [5:0] O_FREEZE = 6'b000000;
  localparam logic [5:0] O_RESET  = 6'b000011;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       memrd;
    logic       br;
    logic       mreq;
    logic       ack;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_opcode       = 7'b0110011;
    id_rs1          = 5'd0;
    id_rs2          = 5'd0;
    ex_rd           = 5'd0;
    ex_memread      = 1'b0;
    ex_branch_taken = 1'b0;
    mem_req_valid   = 1'b0;
    dmem_ack        = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{7'b0110011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
    vt[1]  = '{7'b0110011, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};   // ADD rs2 = LW rd
    vt[2]  = '{7'b0110011, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};   // ADD rs1 = LW rd
    vt[3]  = '{7'b0110111, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM}; // LUI
    vt[4]  = '{7'b0110011, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM}; // rd = x0
    vt[5]  = '{7'b0110011, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM}; // not a load
    vt[6]  = '{7'b0110011, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};   // branch + lu
    vt[7]  = '{7'b0110011, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
    vt[8]  = '{7'b0010011, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM}; // OP-IMM ignores rs2
    vt[9]  = '{7'b0100011, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};   // STORE rs2
    vt[10] = '{7'b1101111, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM}; // JAL
    vt[11] = '{7'b0110011, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_NORM}; // zero-wait mem
    vt[12] = '{7'b1100011, 5'd4, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};   // BRANCH rs2
    vt[13] = '{7'b0001111, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM}; // unlisted opcode
    vt[14] = '{7'b0010111, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM}; // AUIPC
    vt[15] = '{7'b1100111, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};   // JALR rs1

    // Reset asserted from time 0, checked before any clock edge.
    idle();
    rst_n = 1'b0;
    #3;
    check("reset_outs", 32'(outs), 32'(O_RESET));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_outs", 32'(outs), 32'(O_NORM));
    check("post_reset_cnt", 32'(stall_cnt), 32'd0);
    check("post_reset_err", 32'(mem_err), 32'd0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      id_opcode       = vt[i].op;
      id_rs1          = vt[i].rs1;
      id_rs2          = vt[i].rs2;
      ex_rd           = vt[i].rd;
      ex_memread      = vt[i].memrd;
      ex_branch_taken = vt[i].br;
      mem_req_valid   = vt[i].mreq;
      dmem_ack        = vt[i].ack;
      #1;
      check($sformatf("vec%0d", i), 32'(outs), 32'(vt[i].exp));
    end
    @(negedge clk);
    idle();
    #1;
    check("table_stall_cnt", 32'(stall_cnt), 32'd5);

    // Memory wait: ack on the 4th cycle, branch held during the wait.
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      mem_req_valid   = 1'b1;
      dmem_ack        = 1'b0;
      ex_branch_taken = (c >= 2);
      #1;
      check($sformatf("memwait_frz%0d", c), 32'(outs), 32'(O_FREEZE));
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    check("mem_release_br", 32'(outs), 32'(O_BR));
    @(negedge clk);
    idle();
    #1;
    check("mem_after_outs", 32'(outs), 32'(O_NORM));
    check("mem_stall_cnt", 32'(stall_cnt), 32'd3);

    // Request withdrawn after one frozen cycle.
    @(negedge clk);
    mem_req_valid = 1'b1;
    #1;
    check("withdraw_frz", 32'(outs), 32'(O_FREEZE));
    @(negedge clk);
    mem_req_valid = 1'b0;
    #1;
    check("withdraw_rel", 32'(outs), 32'(O_NORM));
    check("withdraw_cnt", 32'(stall_cnt), 32'd4);

    // Timeout: 15 un-acked cycles, then ERROR.
    do_reset();
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      mem_req_valid = 1'b1;
      dmem_ack      = 1'b0;
      #1;
      check($sformatf("to_frz%0d", c), 32'(outs), 32'(O_FREEZE));
      if (c == 14) begin
        check("to_err_before", 32'(mem_err), 32'd0);
        check("to_cnt_before", 32'(stall_cnt), 32'd14);
      end
    end
    @(negedge clk);
    #1;
    check("to_err_set", 32'(mem_err), 32'd1);
    check("to_err_outs", 32'(outs), 32'(O_FREEZE));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dmem_ack = 1'b1;
      #1;
      check($sformatf("err_ack_err%0d", c), 32'(mem_err), 32'd1);
      check($sformatf("err_ack_outs%0d", c), 32'(outs), 32'(O_FREEZE));
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_req_valid = 1'b0;
      dmem_ack      = 1'b0;
    end
    #1;
    check("sat_cnt", 32'(stall_cnt), 32'd15);
    check("sat_err", 32'(mem_err), 32'd1);
    check("sat_outs", 32'(outs), 32'(O_FREEZE));

    // Asynchronous reset out of ERROR, mid-cycle.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", 32'(outs), 32'(O_RESET));
    check("arst_err", 32'(mem_err), 32'd0);
    check("arst_cnt", 32'(stall_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("arst_release_outs", 32'(outs), 32'(O_NORM));
    @(negedge clk);
    #1;
    check("arst_release_err", 32'(mem_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
